// File: rtl/dense_weight_streamer.sv
// rtl/dense_weight_streamer.sv - dense-layer weight ROM streaming LANES zero-point-corrected weights per beat
// ROM contents come from the WEIGHT_INIT parameter (weight n in bits [n*DATA_W +: DATA_W]).
module dense_weight_streamer #(
  parameter int NUM_WEIGHTS = 507,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LANES = 4,
  parameter int OFFSET = 0,
  parameter bit SATURATE = 1'b1,
  parameter logic [NUM_WEIGHTS*DATA_W-1:0] WEIGHT_INIT = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           count,
  output logic                      busy,
  output logic                      done,
  output logic                      oob,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*DATA_W-1:0]   m_data,
  output logic [LANES-1:0]          m_keep,
  output logic                      m_last
);
  localparam int RW = ADDR_W + 2;
  localparam int BW = $clog2(NUM_WEIGHTS*DATA_W);
  localparam logic [DATA_W:0] OFF_EXT = (DATA_W+1)'(OFFSET);
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic [RW-1:0]           rel_q, rel_d;
  logic                    oob_q, oob_d, done_q, done_d;
  logic                    rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [LANES-1:0]        rd_keep_q, rd_keep_d, rd_inr_q, rd_inr_d;
  logic [LANES*DATA_W-1:0] rd_word_q, rd_word_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [LANES*DATA_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [LANES-1:0]        head_keep_q, head_keep_d, tail_keep_q, tail_keep_d;
  logic                    head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic                    issue, last_issue, pop, push;
  logic [LANES-1:0]        lane_oob;
  logic [LANES*DATA_W-1:0] proc_data;

  // Fetch only if the beat it produces is guaranteed a skid slot when it lands.
  always_comb begin
    pop        = (cnt_q != 2'd0) && m_ready;
    push       = rd_valid_q;
    issue      = (state_q == S_FETCH) && (count_q != '0) &&
                 (({1'b0, cnt_q} + {2'b0, rd_valid_q} + 3'd1) <= (3'd2 + {2'b0, pop}));
    last_issue = issue && ((rel_q + RW'(LANES)) >= {1'b0, count_q});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (count_q == '0) state_d = S_IDLE;
        else if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: if (pop && head_last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = done_q;
    oob     = oob_q;
    m_valid = (cnt_q != 2'd0);
    m_data  = head_data_q;
    m_keep  = head_keep_q;
    m_last  = head_last_q && (cnt_q != 2'd0);
  end

  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    rel_d   = rel_q;
    oob_d   = oob_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE && start) begin
      base_d  = base_addr;
      count_d = count;
      rel_d   = '0;
      oob_d   = 1'b0;
    end
    if (issue) begin
      rel_d = rel_q + RW'(LANES);
      oob_d = oob_q | (|lane_oob);
    end
    if (state_q == S_FETCH && count_q == '0) done_d = 1'b1;
    if (state_q == S_DRAIN && pop && head_last_q) done_d = 1'b1;
  end

  // Index math is RW bits wide so base+offset past the ADDR_W range reads as out of bounds.
  always_comb begin
    logic [RW-1:0] lane_rel;
    logic [RW-1:0] lane_idx;
    logic [BW-1:0] bit_idx;
    rd_valid_d = issue;
    rd_last_d  = last_issue;
    rd_keep_d  = '0;
    rd_inr_d   = '0;
    rd_word_d  = '0;
    lane_oob   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_rel     = rel_q + RW'(i);
      lane_idx     = RW'(base_q) + lane_rel;
      rd_keep_d[i] = (lane_rel < {1'b0, count_q});
      rd_inr_d[i]  = (lane_idx < RW'(NUM_WEIGHTS));
      bit_idx      = rd_inr_d[i] ? BW'(32'(lane_idx[ADDR_W-1:0]) * DATA_W) : '0;
      lane_oob[i]  = issue && rd_keep_d[i] && !rd_inr_d[i];
      if (rd_keep_d[i] && rd_inr_d[i]) rd_word_d[i*DATA_W +: DATA_W] = WEIGHT_INIT[bit_idx +: DATA_W];
    end
  end

  always_comb begin
    logic [DATA_W-1:0] w;
    logic [DATA_W:0]   sum;
    proc_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w   = rd_word_q[i*DATA_W +: DATA_W];
      sum = {w[DATA_W-1], w} + OFF_EXT;
      if (rd_keep_q[i] && rd_inr_q[i]) begin
        if (SATURATE && (sum[DATA_W] != sum[DATA_W-1]))
          proc_data[i*DATA_W +: DATA_W] = sum[DATA_W] ? SMIN : SMAX;
        else
          proc_data[i*DATA_W +: DATA_W] = sum[DATA_W-1:0];
      end
    end
  end

  // Two-entry skid FIFO; the head entry is the output register.
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_keep_d = head_keep_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_keep_d = tail_keep_q;
    tail_last_d = tail_last_q;
    case (cnt_q)
      2'd0: if (push) begin
        head_data_d = proc_data; head_keep_d = rd_keep_q; head_last_d = rd_last_q;
        cnt_d = 2'd1;
      end
      2'd1: begin
        if (pop && push) begin
          head_data_d = proc_data; head_keep_d = rd_keep_q; head_last_d = rd_last_q;
        end else if (pop) begin
          cnt_d = 2'd0;
        end else if (push) begin
          tail_data_d = proc_data; tail_keep_d = rd_keep_q; tail_last_d = rd_last_q;
          cnt_d = 2'd2;
        end
      end
      default: if (pop) begin
        head_data_d = tail_data_q; head_keep_d = tail_keep_q; head_last_d = tail_last_q;
        if (push) begin
          tail_data_d = proc_data; tail_keep_d = rd_keep_q; tail_last_d = rd_last_q;
        end else begin
          cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0; count_q <= '0; rel_q <= '0; oob_q <= 1'b0; done_q <= 1'b0;
      rd_valid_q <= 1'b0; rd_last_q <= 1'b0; rd_keep_q <= '0; rd_inr_q <= '0; rd_word_q <= '0;
      cnt_q <= 2'd0;
      head_data_q <= '0; head_keep_q <= '0; head_last_q <= 1'b0;
      tail_data_q <= '0; tail_keep_q <= '0; tail_last_q <= 1'b0;
    end else begin
      base_q <= base_d; count_q <= count_d; rel_q <= rel_d; oob_q <= oob_d; done_q <= done_d;
      rd_valid_q <= rd_valid_d; rd_last_q <= rd_last_d; rd_keep_q <= rd_keep_d;
      rd_inr_q <= rd_inr_d; rd_word_q <= rd_word_d;
      cnt_q <= cnt_d;
      head_data_q <= head_data_d; head_keep_q <= head_keep_d; head_last_q <= head_last_d;
      tail_data_q <= tail_data_d; tail_keep_q <= tail_keep_d; tail_last_q <= tail_last_d;
    end
  end
endmodule

// File: tb/tb_dense_weight_streamer.sv
// tb/tb_dense_weight_streamer.sv - directed bench for dense_weight_streamer
// Weight n holds n-64; three instances share inputs and differ in OFFSET/SATURATE.
module tb_dense_weight_streamer;
  localparam int NW = 507;

  function automatic logic [NW*8-1:0] gen_rom();
    logic [NW*8-1:0] v;
    v = '0;
    for (int n = 0; n < NW; n++) v[n*8 +: 8] = 8'(n - 64);
    return v;
  endfunction
  localparam logic [NW*8-1:0] ROM_INIT = gen_rom();

  logic clk, rst_n, start, m_ready;
  logic [9:0] base_addr;
  logic [10:0] count;
  logic busy, done, oob, m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0] m_keep;
  logic s1_busy, s1_done, s1_oob, s1_valid, s1_last;
  logic [31:0] s1_data;
  logic [3:0] s1_keep;
  logic s0_busy, s0_done, s0_oob, s0_valid, s0_last;
  logic [31:0] s0_data;
  logic [3:0] s0_keep;

  dense_weight_streamer #(.NUM_WEIGHTS(NW), .ADDR_W(10), .DATA_W(8), .LANES(4), .OFFSET(0),
    .SATURATE(1'b1), .WEIGHT_INIT(ROM_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .oob(oob), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last));

  dense_weight_streamer #(.NUM_WEIGHTS(NW), .ADDR_W(10), .DATA_W(8), .LANES(4), .OFFSET(1),
    .SATURATE(1'b1), .WEIGHT_INIT(ROM_INIT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(s1_busy), .done(s1_done), .oob(s1_oob), .m_valid(s1_valid), .m_ready(m_ready),
    .m_data(s1_data), .m_keep(s1_keep), .m_last(s1_last));

  dense_weight_streamer #(.NUM_WEIGHTS(NW), .ADDR_W(10), .DATA_W(8), .LANES(4), .OFFSET(1),
    .SATURATE(1'b0), .WEIGHT_INIT(ROM_INIT)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(s0_busy), .done(s0_done), .oob(s0_oob), .m_valid(s0_valid), .m_ready(m_ready),
    .m_data(s0_data), .m_keep(s0_keep), .m_last(s0_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  logic [31:0] q_d[$];
  logic [3:0]  q_k[$];
  logic        q_l[$];
  logic [63:0] q_s[$];
  logic [11:0] q_f[$];
  int first_valid, done_cyc, n_stalls;
  logic busy1;
  logic [5:0] sdone;

  function automatic logic [31:0] get_d(int k);
    if (k < q_d.size()) return q_d[k];
    return 32'hDEADBEEF;
  endfunction
  function automatic logic [3:0] get_k(int k);
    if (k < q_k.size()) return q_k[k];
    return 4'hx;
  endfunction
  function automatic logic get_l(int k);
    if (k < q_l.size()) return q_l[k];
    return 1'bx;
  endfunction

  function automatic logic [35:0] exp_beat(int b, int c, int k);
    logic [31:0] d;
    logic [3:0] kp;
    d = '0;
    kp = '0;
    for (int i = 0; i < 4; i++) begin
      if (k*4 + i < c) begin
        kp[i] = 1'b1;
        if (b + k*4 + i < NW) d[i*8 +: 8] = 8'(b + k*4 + i - 64);
      end
    end
    return {kp, d};
  endfunction

  // Issues one request and records every handshaken beat until done or budget.
  task automatic run_req(input logic [9:0] b, input logic [10:0] c, input bit rnd,
                         input bit inject, input int budget);
    logic stall_prev;
    logic [31:0] pd;
    logic [3:0] pk;
    logic pl;
    q_d.delete(); q_k.delete(); q_l.delete(); q_s.delete(); q_f.delete();
    first_valid = -1; done_cyc = -1; n_stalls = 0; busy1 = 1'b0; sdone = '0;
    stall_prev = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    @(negedge clk);
    base_addr = b; count = c; start = 1'b1;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && (cyc == 5 || cyc == 9)) begin
        start = 1'b1; base_addr = 10'd3; count = 11'd4;
      end
      if (cyc == 1) busy1 = busy;
      if (done) begin
        done_cyc = cyc;
        check("done_busy_low", busy, 1'b0);
        sdone = {s1_done, s0_done, s1_busy, s0_busy, s1_oob, s0_oob};
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (stall_prev) check("stall_hold", {m_valid, m_data, m_keep, m_last}, {1'b1, pd, pk, pl});
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        q_d.push_back(m_data); q_k.push_back(m_keep); q_l.push_back(m_last);
        q_s.push_back({s1_data, s0_data});
        q_f.push_back({s1_keep, s0_keep, s1_last, s0_last, s1_valid, s0_valid});
      end
      stall_prev = m_valid && !m_ready;
      if (stall_prev) n_stalls++;
      pd = m_data; pk = m_keep; pl = m_last;
    end
    m_ready = 1'b1;
    start = 1'b0;
  endtask

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, oob, m_valid, m_last}, 5'b0);
    check("rst_data", {m_data, m_keep}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(10'd0, 11'd8, 1'b0, 1'b0, 60);
    check("t1_first_valid", first_valid, 3);
    check("t1_beats", q_d.size(), 2);
    check("t1_d0", get_d(0), 32'hC3C2C1C0);
    check("t1_d1", get_d(1), 32'hC7C6C5C4);
    check("t1_kl0", {get_k(0), get_l(0)}, {4'hF, 1'b0});
    check("t1_kl1", {get_k(1), get_l(1)}, {4'hF, 1'b1});
    check("t1_done_cyc", done_cyc, 5);
    check("t1_busy", busy1, 1'b1);
    check("t1_oob", oob, 1'b0);

    run_req(10'd10, 11'd6, 1'b0, 1'b0, 60);
    check("t2_beats", q_d.size(), 2);
    check("t2_d0", get_d(0), 32'hCDCCCBCA);
    check("t2_d1", get_d(1), 32'h0000CFCE);
    check("t2_kl0", {get_k(0), get_l(0)}, {4'hF, 1'b0});
    check("t2_kl1", {get_k(1), get_l(1)}, {4'b0011, 1'b1});

    run_req(10'd191, 11'd2, 1'b0, 1'b0, 60);
    check("t3_beats", q_d.size(), 1);
    check("t3_off0", get_d(0), 32'h0000807F);
    check("t3_sat_wrap", (q_s.size() > 0) ? q_s[0] : 64'hx, {32'h0000817F, 32'h00008180});
    check("t3_flags", (q_f.size() > 0) ? q_f[0] : 12'hx, 12'h33F);
    check("t3_done_cyc", done_cyc, 4);
    check("t3_sdone", sdone, 6'b110000);

    run_req(10'd505, 11'd4, 1'b0, 1'b0, 60);
    check("t4_beats", q_d.size(), 1);
    check("t4_d0", get_d(0), 32'h0000BAB9);
    check("t4_kl0", {get_k(0), get_l(0)}, {4'hF, 1'b1});
    check("t4_oob", oob, 1'b1);

    run_req(10'd0, 11'd0, 1'b0, 1'b0, 20);
    check("c0_no_valid", first_valid, -1);
    check("c0_beats", q_d.size(), 0);
    check("c0_done_cyc", done_cyc, 2);
    check("c0_busy", busy1, 1'b1);
    check("c0_oob_cleared", oob, 1'b0);

    run_req(10'd100, 11'd40, 1'b1, 1'b1, 400);
    check("t5_done_seen", done_cyc > 0, 1'b1);
    check("t5_beats", q_d.size(), 10);
    check("t5_stalls_seen", n_stalls > 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("t5_beat", {get_k(k), get_d(k)}, exp_beat(100, 40, k));
      check("t5_last", get_l(k), k == 9);
    end

    @(negedge clk);
    base_addr = 10'd0; count = 11'd40; start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    rst_n = 1'b1;
    @(negedge clk);
    seen_done = seen_done | done | busy;
    check("t6_no_done", seen_done, 1'b0);
    run_req(10'd0, 11'd8, 1'b0, 1'b0, 60);
    check("t6_first_valid", first_valid, 3);
    check("t6_d0", get_d(0), 32'hC3C2C1C0);
    check("t6_d1", get_d(1), 32'hC7C6C5C4);
    check("t6_done_cyc", done_cyc, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
